// File: rtl/ps2_host_controller.sv
// rtl/ps2_host_controller.sv - PS/2 host command sequencer with retry and timeout
//
// Ports:
//   clock, reset                 system clock, asynchronous active-high reset
//   ps2_clock_in, ps2_data_in    raw PS/2 pin levels, synchronized internally
//   ps2_clock_oe, ps2_data_oe    1 = pull the line low, 0 = release
//   cmd_byte, cmd_valid          command byte request
//   cmd_ready                    high only while idle
//   rx_byte, rx_valid            response byte from the PS/2 receiver
//   rx_enable                    receiver gate, low while the host owns the bus
//   done, error                  one-cycle completion / failure pulses

module ps2_host_controller #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int MAX_RETRIES    = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clock_in,
  input  logic       ps2_data_in,
  output logic       ps2_clock_oe,
  output logic       ps2_data_oe,
  input  logic [7:0] cmd_byte,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  output logic       rx_enable,
  output logic       done,
  output logic       error
);

  localparam int TIMER_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int TIMER_W   = $clog2(TIMER_MAX + 1);
  localparam int RETRY_W   = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

  // INHIBIT is left one cycle early: the REQ cycle still holds the clock low,
  // so the clock line is pulled for exactly INHIBIT_CYCLES cycles in total.
  localparam logic [TIMER_W-1:0] INHIBIT_LAST = TIMER_W'(INHIBIT_CYCLES - 2);
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

  localparam logic [7:0] RESP_ACK    = 8'hFA;
  localparam logic [7:0] RESP_RESEND = 8'hFE;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_REQ       = 3'd2,
    ST_SEND      = 3'd3,
    ST_LINE_ACK  = 3'd4,
    ST_WAIT_RESP = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [3:0]         bit_idx_q, bit_idx_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [7:0]         cmd_q, cmd_d;
  logic               parity_q, parity_d;

  logic clock_oe_q, clock_oe_d;
  logic data_oe_q, data_oe_d;
  logic cmd_ready_q, cmd_ready_d;
  logic rx_enable_q, rx_enable_d;
  logic done_q, done_d;
  logic error_q, error_d;

  logic clk_meta_q, clk_meta_d;
  logic clk_sync_q, clk_sync_d;
  logic clk_prev_q, clk_prev_d;
  logic data_meta_q, data_meta_d;
  logic data_sync_q, data_sync_d;

  logic clk_fall;
  logic attempt_fail;
  logic timed_out;

  // Synchronizers; the previous synchronized clock feeds the falling-edge detect.
  always_comb begin
    clk_meta_d  = ps2_clock_in;
    clk_sync_d  = clk_meta_q;
    clk_prev_d  = clk_sync_q;
    data_meta_d = ps2_data_in;
    data_sync_d = data_meta_q;
  end

  assign clk_fall  = clk_prev_q & ~clk_sync_q;
  assign timed_out = (timer_q == TIMEOUT_LAST);

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    bit_idx_d    = bit_idx_q;
    retry_d      = retry_q;
    cmd_d        = cmd_q;
    parity_d     = parity_q;
    clock_oe_d   = clock_oe_q;
    data_oe_d    = data_oe_q;
    done_d       = 1'b0;
    error_d      = 1'b0;
    attempt_fail = 1'b0;

    case (state_q)
      ST_IDLE: begin
        clock_oe_d = 1'b0;
        data_oe_d  = 1'b0;
        bit_idx_d  = 4'd0;
        if (cmd_valid && cmd_ready_q) begin
          cmd_d      = cmd_byte;
          parity_d   = ~^cmd_byte;
          retry_d    = '0;
          clock_oe_d = 1'b1;
          state_d    = ST_INHIBIT;
        end
      end

      ST_INHIBIT: begin
        clock_oe_d = 1'b1;
        data_oe_d  = 1'b0;
        timer_d    = timer_q + TIMER_W'(1);
        if (timer_q == INHIBIT_LAST) begin
          data_oe_d = 1'b1;
          state_d   = ST_REQ;
        end
      end

      ST_REQ: begin
        clock_oe_d = 1'b0;
        data_oe_d  = 1'b1;
        bit_idx_d  = 4'd0;
        state_d    = ST_SEND;
      end

      ST_SEND: begin
        timer_d = timer_q + TIMER_W'(1);
        if (clk_fall) begin
          timer_d   = '0;
          bit_idx_d = bit_idx_q + 4'd1;
          if (bit_idx_q < 4'd8) begin
            data_oe_d = ~cmd_q[bit_idx_q[2:0]];
          end else if (bit_idx_q == 4'd8) begin
            data_oe_d = ~parity_q;
          end else begin
            data_oe_d = 1'b0;
            state_d   = ST_LINE_ACK;
          end
        end else if (timed_out) begin
          attempt_fail = 1'b1;
        end
      end

      ST_LINE_ACK: begin
        timer_d = timer_q + TIMER_W'(1);
        if (clk_fall) begin
          timer_d = '0;
          if (!data_sync_q) begin
            state_d = ST_WAIT_RESP;
          end else begin
            attempt_fail = 1'b1;
          end
        end else if (timed_out) begin
          attempt_fail = 1'b1;
        end
      end

      ST_WAIT_RESP: begin
        timer_d = timer_q + TIMER_W'(1);
        if (rx_valid) begin
          if (rx_byte == RESP_ACK) begin
            done_d  = 1'b1;
            retry_d = '0;
            state_d = ST_IDLE;
          end else if (rx_byte == RESP_RESEND) begin
            attempt_fail = 1'b1;
          end else begin
            error_d = 1'b1;
            retry_d = '0;
            state_d = ST_IDLE;
          end
        end else if (clk_fall) begin
          // Response bytes from the keyboard keep the link alive.
          timer_d = '0;
        end else if (timed_out) begin
          attempt_fail = 1'b1;
        end
      end

      default: begin
        clock_oe_d = 1'b0;
        data_oe_d  = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase

    // Resend, NACK and timeout all funnel here: retry the latched byte or give up.
    if (attempt_fail) begin
      clock_oe_d = 1'b0;
      data_oe_d  = 1'b0;
      if (retry_q < RETRY_LIMIT) begin
        retry_d    = retry_q + RETRY_W'(1);
        clock_oe_d = 1'b1;
        state_d    = ST_INHIBIT;
      end else begin
        retry_d = '0;
        error_d = 1'b1;
        state_d = ST_IDLE;
      end
    end

    if (state_d != state_q) begin
      timer_d = '0;
    end

    cmd_ready_d = (state_d == ST_IDLE);
    rx_enable_d = (state_d == ST_IDLE) || (state_d == ST_WAIT_RESP);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      bit_idx_q   <= 4'd0;
      retry_q     <= '0;
      cmd_q       <= 8'h00;
      parity_q    <= 1'b0;
      clock_oe_q  <= 1'b0;
      data_oe_q   <= 1'b0;
      cmd_ready_q <= 1'b1;
      rx_enable_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      // Idle PS/2 lines float high.
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      clk_prev_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      bit_idx_q   <= bit_idx_d;
      retry_q     <= retry_d;
      cmd_q       <= cmd_d;
      parity_q    <= parity_d;
      clock_oe_q  <= clock_oe_d;
      data_oe_q   <= data_oe_d;
      cmd_ready_q <= cmd_ready_d;
      rx_enable_q <= rx_enable_d;
      done_q      <= done_d;
      error_q     <= error_d;
      clk_meta_q  <= clk_meta_d;
      clk_sync_q  <= clk_sync_d;
      clk_prev_q  <= clk_prev_d;
      data_meta_q <= data_meta_d;
      data_sync_q <= data_sync_d;
    end
  end

  assign ps2_clock_oe = clock_oe_q;
  assign ps2_data_oe  = data_oe_q;
  assign cmd_ready    = cmd_ready_q;
  assign rx_enable    = rx_enable_q;
  assign done         = done_q;
  assign error        = error_q;

endmodule

// File: tb/tb_ps2_host_controller.sv
// tb/tb_ps2_host_controller.sv - scoreboard bench for ps2_host_controller

module tb_ps2_host_controller;

  localparam int INH     = 20;
  localparam int TMO     = 400;
  localparam int RETRIES = 3;
  localparam int HALF    = 8;
  localparam int GAP     = 20;

  localparam logic [1:0] EV_DONE  = 2'b10;
  localparam logic [1:0] EV_ERROR = 2'b01;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_clock_in;
  logic       ps2_data_in;
  logic       ps2_clock_oe;
  logic       ps2_data_oe;
  logic [7:0] cmd_byte = 8'h00;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_enable;
  logic       done;
  logic       error;

  int n_cmp = 0;
  int n_bad = 0;

  logic [10:0] exp_frame_q[$];
  logic [1:0]  exp_evt_q[$];
  int          exp_inh_q[$];
  logic [10:0] last_seen;

  // Open-drain lines: either side may pull low.
  assign ps2_clock_in = dev_clk & ~ps2_clock_oe;
  assign ps2_data_in  = dev_data & ~ps2_data_oe;

  always #5 clock = ~clock;

  ps2_host_controller #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO),
    .MAX_RETRIES(RETRIES)
  ) dut (
    .clock(clock),
    .reset(reset),
    .ps2_clock_in(ps2_clock_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clock_oe(ps2_clock_oe),
    .ps2_data_oe(ps2_data_oe),
    .cmd_byte(cmd_byte),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .rx_byte(rx_byte),
    .rx_valid(rx_valid),
    .rx_enable(rx_enable),
    .done(done),
    .error(error)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Outcome monitor: every done/error pulse must match the next expected outcome.
  always @(negedge clock) begin
    if (!reset && (done || error)) begin
      check("pulse_exclusive", 32'(done && error), 32'd0);
      if (exp_evt_q.size() == 0) begin
        check("unexpected_pulse", {30'd0, done, error}, 32'd0);
      end else begin
        check("outcome", {30'd0, done, error}, {30'd0, exp_evt_q.pop_front()});
        check("ready_at_pulse", 32'(cmd_ready), 32'd1);
        check("lines_at_pulse", {30'd0, ps2_clock_oe, ps2_data_oe}, 32'd0);
      end
    end
  end

  // Inhibit monitor: width of each clock-low interval driven by the host.
  int inh_cnt = 0;
  always @(negedge clock) begin
    if (reset) begin
      inh_cnt = 0;
    end else if (ps2_clock_oe) begin
      inh_cnt++;
    end else if (inh_cnt != 0) begin
      if (exp_inh_q.size() == 0) check("unexpected_inhibit", 32'(inh_cnt), 32'd0);
      else check("inhibit_width", 32'(inh_cnt), 32'(exp_inh_q.pop_front()));
      inh_cnt = 0;
    end
  end

  task automatic send_cmd(input logic [7:0] b);
    @(negedge clock);
    check("ready_before_cmd", 32'(cmd_ready), 32'd1);
    cmd_byte  = b;
    cmd_valid = 1'b1;
    @(negedge clock);
    cmd_valid = 1'b0;
    check("accept_latency_clock_oe", 32'(ps2_clock_oe), 32'd1);
    check("rx_gated_after_accept", 32'(rx_enable), 32'd0);
  endtask

  task automatic wait_req(output logic ok);
    ok = 1'b0;
    for (int n = 0; n < 4 * (INH + TMO); n++) begin
      @(negedge clock);
      if (!ps2_clock_oe && ps2_data_oe) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("request_to_send_seen", 32'd0, 32'd1);
  endtask

  // Device clocking: sample the host's data drive in each high phase, then fall.
  task automatic device_frame(input int edges, input logic ack, output logic [10:0] seen);
    seen = '0;
    for (int k = 0; k < edges; k++) begin
      repeat (HALF) @(negedge clock);
      seen[k] = ps2_data_oe;
      if (k == 10 && ack) dev_data = 1'b0;
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clock);
      dev_clk = 1'b1;
    end
    repeat (HALF) @(negedge clock);
    dev_data = 1'b1;
  endtask

  task automatic respond(input logic [7:0] b);
    repeat (GAP) @(negedge clock);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(negedge clock);
    rx_valid = 1'b0;
  endtask

  task automatic run_attempt(input logic [7:0] resp);
    logic ok;
    logic [10:0] seen;
    wait_req(ok);
    if (ok) begin
      device_frame(11, 1'b1, seen);
      last_seen = seen;
      if (exp_frame_q.size() == 0) check("unexpected_frame", 32'(seen), 32'd0);
      else check("frame_data_oe", 32'(seen), 32'(exp_frame_q.pop_front()));
      check("rx_enable_wait_resp", 32'(rx_enable), 32'd1);
      respond(resp);
    end
  endtask

  task automatic wait_idle(input int limit, output int attempts);
    logic prev;
    prev = 1'b0;
    attempts = 0;
    for (int n = 0; n < limit; n++) begin
      if (ps2_clock_oe && !prev) attempts++;
      prev = ps2_clock_oe;
      if (cmd_ready) break;
      @(negedge clock);
    end
    check("idle_reached", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    logic [10:0] seen;
    int att;

    repeat (3) @(negedge clock);
    check("rst_clock_oe", 32'(ps2_clock_oe), 32'd0);
    check("rst_data_oe", 32'(ps2_data_oe), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_rx_enable", 32'(rx_enable), 32'd1);
    check("rst_done_error", {30'd0, done, error}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // 1: 0xED, acked and answered 0xFA
    exp_frame_q.push_back(11'h025);
    exp_inh_q.push_back(INH);
    exp_evt_q.push_back(EV_DONE);
    send_cmd(8'hED);
    run_attempt(8'hFA);
    wait_idle(200, att);

    // 2: 0x07, parity bit 0 is driven low
    exp_frame_q.push_back(11'h3F1);
    exp_inh_q.push_back(INH);
    exp_evt_q.push_back(EV_DONE);
    send_cmd(8'h07);
    run_attempt(8'hFA);
    check("parity_oe_0x07", 32'(last_seen[9]), 32'd1);
    wait_idle(200, att);

    // 3: two resends, then ack
    for (int i = 0; i < 3; i++) begin
      exp_frame_q.push_back(11'h001);
      exp_inh_q.push_back(INH);
    end
    exp_evt_q.push_back(EV_DONE);
    send_cmd(8'hFF);
    run_attempt(8'hFE);
    run_attempt(8'hFE);
    run_attempt(8'hFA);
    wait_idle(200, att);

    // 4: device never clocks
    for (int i = 0; i < 1 + RETRIES; i++) exp_inh_q.push_back(INH);
    exp_evt_q.push_back(EV_ERROR);
    send_cmd(8'hEE);
    wait_idle(8 * (INH + TMO), att);
    check("timeout_attempts", 32'(att), 32'd4);
    @(negedge clock);
    check("timeout_lines_released", {30'd0, ps2_clock_oe, ps2_data_oe}, 32'd0);

    // 5: reset during SEND bit 4, then 0x55
    exp_inh_q.push_back(INH);
    send_cmd(8'hA3);
    wait_req(ok);
    device_frame(4, 1'b0, seen);
    check("partial_frame", 32'(seen[3:0]), 32'h9);
    check("data_low_before_reset", 32'(ps2_data_oe), 32'd1);
    reset = 1'b1;
    #1;
    check("reset_async_oe", {30'd0, ps2_clock_oe, ps2_data_oe}, 32'd0);
    check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    check("reset_no_pulse", {30'd0, done, error}, 32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    check("after_reset_idle", {29'd0, cmd_ready, ps2_clock_oe, ps2_data_oe}, 32'h4);
    exp_frame_q.push_back(11'h155);
    exp_inh_q.push_back(INH);
    exp_evt_q.push_back(EV_DONE);
    send_cmd(8'h55);
    run_attempt(8'hFA);
    wait_idle(200, att);

    // 6: stray rx_valid during SEND, stray cmd_valid during WAIT_RESP
    exp_frame_q.push_back(11'h217);
    exp_inh_q.push_back(INH);
    exp_evt_q.push_back(EV_DONE);
    send_cmd(8'hF4);
    wait_req(ok);
    if (ok) begin
      fork
        device_frame(11, 1'b1, seen);
        begin
          repeat (40) @(negedge clock);
          check("rx_enable_in_send", 32'(rx_enable), 32'd0);
          rx_byte  = 8'hAA;
          rx_valid = 1'b1;
          @(negedge clock);
          rx_valid = 1'b0;
        end
      join
      check("frame_data_oe", 32'(seen), 32'(exp_frame_q.pop_front()));
      cmd_byte  = 8'h12;
      cmd_valid = 1'b1;
      repeat (3) @(negedge clock);
      check("ready_low_wait_resp", 32'(cmd_ready), 32'd0);
      cmd_valid = 1'b0;
      respond(8'hFA);
    end
    wait_idle(200, att);
    repeat (30) @(negedge clock);
    check("stray_cmd_ignored", {30'd0, ps2_clock_oe, cmd_ready}, 32'd1);

    repeat (20) @(negedge clock);
    check("frames_pending", 32'(exp_frame_q.size()), 32'd0);
    check("outcomes_pending", 32'(exp_evt_q.size()), 32'd0);
    check("inhibits_pending", 32'(exp_inh_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
